avmm_memtest_master: RTL and testbench
======================================

// Module: avmm_memtest_master
// PURPOSE
// Avalon-MM master that exercises an Avalon-MM slave memory (e.g. the on-chip RAM, s1 port).
// On start it writes a generated pattern over a word range, reads the range back with
// pipelined reads, and compares every returned word. Reports busy/done, an error count and
// the first failing address.
// Sits in the test core beside the memory and is started and observed by a control block.
// PARAMETERS
// ADDR_W       12   word-address width; the byte address is ADDR_W+2 bits
// MAX_PENDING  4    maximum outstanding reads (1..15)
// PORTS
// clk                in   1         system clock
// reset_n            in   1         asynchronous active-low reset
// start              in   1         1-cycle pulse; starts a test when idle
// base_addr          in   ADDR_W    first word address; sampled on start
// word_count         in   ADDR_W+1  number of words; sampled on start
// busy               out  1         high from start until done
// done               out  1         1-cycle pulse when the test completes
// err_count          out  16        mismatches found; saturates at 16'hFFFF
// first_err_addr     out  ADDR_W    word address of the first mismatch
// avm_address        out  ADDR_W+2  byte address; bits [1:0] are always 0
// avm_read           out  1         read request
// avm_write          out  1         write request
// avm_writedata      out  32        write data
// avm_byteenable     out  4         always 4'hF
// avm_waitrequest    in   1         slave stall
// avm_readdata       in   32        read data
// avm_readdatavalid  in   1         read data strobe
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE, all outputs 0 except avm_byteenable=4'hF.
// - FSM: IDLE -start&&count!=0-> WRITE -last write accepted-> READ -last read accepted-> DRAIN
//   -pending==0-> DONE -(1 cycle, done=1)-> IDLE.
// - IDLE with start&&count==0: go straight to DONE. No bus traffic, err_count=0.
// - start in any state other than IDLE is ignored.
// - On an accepted start: err_count and first_err_addr clear; busy=1 from the next cycle.
// - Command handshake: address, data, read and write stay stable while avm_waitrequest=1.
//   A command is accepted on a cycle with req && !avm_waitrequest. The next command may be
//   presented the following cycle, giving 1 word per clock with no stall.
// - avm_read and avm_write are never high together.
// - WRITE: word i goes to (base_addr+i) mod 2^ADDR_W; address wrap is silent.
// - READ: a read is issued only while pending < MAX_PENDING.
// - pending counter: +1 on an accepted read, -1 on readdatavalid; both in one cycle = no
//   change. No assumption on read latency (>=1).
// - Compare: each readdatavalid is checked against the expected word for the oldest
//   outstanding read. A separate check-side generator replays the pattern in order.
// - Mismatch: err_count+1 (saturating). On the first mismatch only, first_err_addr is
//   captured as the word address.
// - readdatavalid in IDLE/WRITE/DONE is ignored.
// - Pattern, default: data(i) = 32'hA5A5_0000 ^ i, where i is the word index zero-extended.
// - err_count and first_err_addr hold after done until the next accepted start.
// CONFIGURATION
// MEMTEST_LFSR_PATTERN_EN defined:
//   pattern = 32-bit Galois LFSR, x^32+x^22+x^2+x+1, seed 32'hFFFF_FFFF, one step per word.
//   Write-side and check-side generators are both reseeded on start.
// MEMTEST_LFSR_PATTERN_EN undefined:
//   address-XOR pattern above; no LFSR logic is synthesised.
// STRUCTURE
// Package memtest_pkg: FSM state enum (IDLE, WRITE, READ, DRAIN, DONE), PATTERN_XOR
// constant, LFSR polynomial and seed.
// One sub-module, memtest_patgen: parameterless pattern generator with load/step/data.
// It is instantiated twice, once for the write side and once for the check side.
// TESTING
// - count=8, base=0, latency-1 RAM model, waitrequest=0 -> 8 writes on 8 consecutive
//   cycles, 8 reads, done, err_count=0.
// - count=4, base=12'hFFE -> addresses wrap: words FFE, FFF, 000, 001 are written and read;
//   err_count=0.
// - RAM model corrupts word 5 (bit0 flipped) and word 6, count=16 -> err_count=2,
//   first_err_addr=base+5.
// - random waitrequest (50%) and read latency 1..6 -> pending never exceeds MAX_PENDING,
//   commands stable while stalled, err_count=0.
// - count=0 -> done pulse 1 cycle after start, no avm_read/avm_write asserted.
// - reset_n low mid-READ with 3 reads outstanding -> outputs 0 immediately; a new start
//   after release runs clean with err_count=0.

Source files
------------

// File: rtl/memtest_pkg.sv
// ----------------------------------------------------------------------------
// memtest_pkg
// Shared definitions for the Avalon-MM memory test master:
//   state_t      - controller FSM states
//   PATTERN_XOR  - constant folded into the default address-XOR pattern
//   LFSR_POLY    - Galois (right-shift) tap mask for x^32+x^22+x^2+x+1
//   LFSR_SEED    - LFSR start value, reloaded on every test start
//   lfsr_next()  - one Galois LFSR step
// ----------------------------------------------------------------------------
package memtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] PATTERN_XOR = 32'hA5A5_0000;
    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED   = 32'hFFFF_FFFF;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/memtest_patgen.sv
// ----------------------------------------------------------------------------
// memtest_patgen
// Test pattern generator. One instance feeds the write side, a second one
// replays the identical sequence for the read-back compare.
// Build option: MEMTEST_LFSR_PATTERN_EN selects a 32-bit Galois LFSR pattern;
// otherwise the pattern is PATTERN_XOR ^ word_index.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   load     in   restart the sequence at word 0
//   step     in   advance to the next word
//   data     out  pattern word for the current index
// ----------------------------------------------------------------------------
module memtest_patgen
    import memtest_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] data
);

`ifdef MEMTEST_LFSR_PATTERN_EN
    logic [31:0] lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (load) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign data = lfsr_q;
`else
    logic [31:0] idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else if (load) begin
            idx_q <= '0;
        end else if (step) begin
            idx_q <= idx_q + 32'd1;
        end
    end

    assign data = PATTERN_XOR ^ idx_q;
`endif

endmodule

// File: rtl/avmm_memtest_master.sv
// ----------------------------------------------------------------------------
// avmm_memtest_master
// Avalon-MM master that writes a generated pattern over a word range of a
// slave memory, reads the range back with up to MAX_PENDING pipelined reads
// and compares every returned word against a replayed copy of the pattern.
// Build option: MEMTEST_LFSR_PATTERN_EN (LFSR pattern instead of address-XOR).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               1-cycle start pulse (ignored unless idle)
//   base_addr           first word address, sampled on start
//   word_count          number of words, sampled on start
//   busy, done          status; done pulses one cycle at completion
//   err_count           saturating mismatch count
//   first_err_addr      word address of the first mismatch
//   avm_*               Avalon-MM master interface (byte addressed)
// ----------------------------------------------------------------------------
module avmm_memtest_master
    import memtest_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [PEND_W-1:0] PEND_ONE = 1;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, addr_q, chk_addr_q;
    logic [ADDR_W:0]   count_q, remain_q;
    logic [PEND_W-1:0] pending_q;
    logic              err_seen_q;
    logic [31:0]       wr_data, chk_data;
    logic              start_acc, wr_acc, rd_acc, rdv_acc, last_cmd, mismatch;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign last_cmd = (remain_q == CNT_ONE);
    assign wr_acc   = avm_write && !avm_waitrequest;
    assign rd_acc   = avm_read && !avm_waitrequest;
    // Read data outside the read/drain phases cannot belong to this test.
    assign rdv_acc  = avm_readdatavalid && (state == READ || state == DRAIN);
    assign mismatch = rdv_acc && (avm_readdata != chk_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        avm_read  = 1'b0;
        avm_write = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (word_count == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                avm_write = 1'b1;
                if (!avm_waitrequest && last_cmd) state_nxt = READ;
            end
            READ: begin
                // Once presented, a stalled read stays valid: pending can only
                // fall while the request is held.
                avm_read = (pending_q < PEND_MAX);
                if (avm_read && !avm_waitrequest && last_cmd) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pending_q == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign avm_address    = (state == WRITE || state == READ) ? {addr_q, 2'b00} : '0;
    assign avm_writedata  = (state == WRITE) ? wr_data : '0;
    assign avm_byteenable = 4'hF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q         <= '0;
            count_q        <= '0;
            addr_q         <= '0;
            remain_q       <= '0;
            chk_addr_q     <= '0;
            pending_q      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen_q     <= 1'b0;
        end else if (start_acc) begin
            base_q         <= base_addr;
            count_q        <= word_count;
            addr_q         <= base_addr;
            remain_q       <= word_count;
            chk_addr_q     <= base_addr;
            pending_q      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                // After the last write the same counters walk the read pass.
                if (last_cmd) begin
                    addr_q   <= base_q;
                    remain_q <= count_q;
                end else begin
                    addr_q   <= addr_q + ADDR_ONE;
                    remain_q <= remain_q - CNT_ONE;
                end
            end
            if (rd_acc) begin
                addr_q   <= addr_q + ADDR_ONE;
                remain_q <= remain_q - CNT_ONE;
            end
            case ({rd_acc, rdv_acc})
                2'b10:   pending_q <= pending_q + PEND_ONE;
                2'b01:   pending_q <= pending_q - PEND_ONE;
                default: pending_q <= pending_q;
            endcase
            if (rdv_acc) chk_addr_q <= chk_addr_q + ADDR_ONE;
            if (mismatch) begin
                err_count <= sat_inc(err_count);
                if (!err_seen_q) begin
                    first_err_addr <= chk_addr_q;
                    err_seen_q     <= 1'b1;
                end
            end
        end
    end

    memtest_patgen u_wr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_acc),
        .step    (wr_acc),
        .data    (wr_data)
    );

    memtest_patgen u_chk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_acc),
        .step    (rdv_acc),
        .data    (chk_data)
    );

endmodule

// File: tb/tb_avmm_memtest_master.sv
module tb_avmm_memtest_master;

    localparam int ADDR_W      = 12;
    localparam int MAX_PENDING = 4;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    avmm_memtest_master #(.ADDR_W(ADDR_W), .MAX_PENDING(MAX_PENDING)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks, errors;

    // Slave memory model and traffic monitor state
    logic [31:0] mem  [0:DEPTH-1];
    logic [31:0] flip [0:DEPTH-1];
    typedef struct { logic [31:0] data; int due; } rsp_t;
    rsp_t rq[$];
    rsp_t rsp;
    int cyc, wait_pct, lat_min, lat_max, due;
    int n_wr, n_rd, first_wr_cyc, last_wr_cyc, outstanding, max_out;
    int viol_stable, viol_both, viol_be, viol_align, traffic;
    int done_cnt, done_cyc, start_cyc;
    logic [ADDR_W-1:0] widx;
    logic              prev_stall, prev_read, prev_write;
    logic [ADDR_W+1:0] prev_addr;
    logic [31:0]       prev_data;

    // Reference pattern, computed directly from the word index.
    function automatic logic [31:0] pat(input int i);
`ifdef MEMTEST_LFSR_PATTERN_EN
        logic [31:0] s;
        s = 32'hFFFF_FFFF;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
`else
        return 32'hA5A5_0000 ^ 32'(i);
`endif
    endfunction

    function automatic int wrap(input int a);
        return a % DEPTH;
    endfunction

    function automatic int mem_bad(input int b, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) if (mem[wrap(b + i)] !== pat(i)) bad++;
        return bad;
    endfunction

    function automatic int exp_errs(input int b, input int n);
        int e;
        e = 0;
        for (int i = 0; i < n; i++) if (flip[wrap(b + i)] != 0) e++;
        return e;
    endfunction

    function automatic int exp_first(input int b, input int n);
        for (int i = 0; i < n; i++) if (flip[wrap(b + i)] != 0) return wrap(b + i);
        return 0;
    endfunction

    // Avalon-MM slave: everything for a cycle is decided at the falling edge.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        cyc = 0; outstanding = 0; prev_stall = 1'b0;
        prev_read = 1'b0; prev_write = 1'b0; prev_addr = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                rq.delete();
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_readdata      = '0;
                outstanding       = 0;
                prev_stall        = 1'b0;
                continue;
            end
            if (prev_stall && (avm_read !== prev_read || avm_write !== prev_write ||
                avm_address !== prev_addr || (prev_write && avm_writedata !== prev_data)))
                viol_stable++;
            if (avm_read && avm_write) viol_both++;
            if (avm_byteenable !== 4'hF) viol_be++;
            if (avm_address[1:0] !== 2'b00) viol_align++;
            if (avm_read || avm_write) traffic++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rq[0].data;
                void'(rq.pop_front());
                outstanding--;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = $urandom;
            end
            avm_waitrequest = ($urandom_range(99) < wait_pct);
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                widx = avm_address[ADDR_W+1:2];
                if (avm_write) begin
                    mem[widx] = avm_writedata;
                    n_wr++;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                end else begin
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (rq.size() > 0 && due <= rq[$].due) due = rq[$].due + 1;
                    rsp.data = mem[widx] ^ flip[widx];
                    rsp.due  = due;
                    rq.push_back(rsp);
                    outstanding++;
                    n_rd++;
                    if (outstanding > max_out) max_out = outstanding;
                end
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            prev_read  = avm_read;
            prev_write = avm_write;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    task automatic prep_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = SENTINEL;
            flip[i] = '0;
        end
    endtask

    task automatic start_run(input int b, input int n, input int wp, input int lmin, input int lmax);
        @(negedge clk);
        #1;
        n_wr = 0; n_rd = 0; first_wr_cyc = -1; last_wr_cyc = -1; max_out = 0;
        viol_stable = 0; viol_both = 0; viol_be = 0; viol_align = 0; traffic = 0;
        done_cnt = 0; done_cyc = -1;
        wait_pct = wp; lat_min = lmin; lat_max = lmax;
        base_addr  = ADDR_W'(b);
        word_count = (ADDR_W+1)'(n);
        start      = 1'b1;
        start_cyc  = cyc;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, avm_read, avm_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, avm_read, avm_write});
        end
        checks++;
        if (err_count !== 16'd0 || first_err_addr !== '0) begin
            errors++; $display("FAIL reset_err: got %0h/%0h want 0/0", err_count, first_err_addr);
        end
        checks++;
        if (avm_address !== '0 || avm_writedata !== '0) begin
            errors++; $display("FAIL reset_bus: got %0h/%0h want 0/0", avm_address, avm_writedata);
        end
        checks++;
        if (avm_byteenable !== 4'hF) begin
            errors++; $display("FAIL reset_be: got %h want f", avm_byteenable);
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, avm_read, avm_write} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset: got %b want 000", {busy, avm_read, avm_write});
        end
    endtask

    task automatic test_basic();
        bit to;
        prep_mem();
        start_run(0, 8, 0, 1, 1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: got timeout want done"); end
        checks++;
        if (n_wr !== 8 || n_rd !== 8) begin
            errors++; $display("FAIL basic_counts: got wr=%0d rd=%0d want 8/8", n_wr, n_rd);
        end
        checks++;
        if (last_wr_cyc - first_wr_cyc !== 7 || first_wr_cyc !== start_cyc + 1) begin
            errors++; $display("FAIL basic_wr_timing: got first=%0d span=%0d want %0d/7",
                               first_wr_cyc - start_cyc, last_wr_cyc - first_wr_cyc, 1);
        end
        checks++;
        if (mem_bad(0, 8) !== 0) begin errors++; $display("FAIL basic_mem: got %0d bad want 0", mem_bad(0, 8)); end
        checks++;
        if (err_count !== 16'd0 || first_err_addr !== '0) begin
            errors++; $display("FAIL basic_err: got %0d/%0h want 0/0", err_count, first_err_addr);
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done: got pulses=%0d busy=%b want 1/0", done_cnt, busy);
        end
        checks++;
        if (viol_both + viol_be + viol_align !== 0) begin
            errors++; $display("FAIL basic_protocol: got %0d want 0", viol_both + viol_be + viol_align);
        end
    endtask

    task automatic test_wrap();
        bit to;
        prep_mem();
        start_run(12'hFFE, 4, 0, 1, 1);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL wrap_timeout: got timeout want done"); end
        checks++;
        if (mem_bad(12'hFFE, 4) !== 0) begin errors++; $display("FAIL wrap_mem: got %0d bad want 0", mem_bad(12'hFFE, 4)); end
        checks++;
        if (mem[12'hFFD] !== SENTINEL || mem[2] !== SENTINEL) begin
            errors++; $display("FAIL wrap_outside: got %0h/%0h want %0h", mem[12'hFFD], mem[2], SENTINEL);
        end
        checks++;
        if (err_count !== 16'd0 || n_rd !== 4) begin
            errors++; $display("FAIL wrap_err: got err=%0d rd=%0d want 0/4", err_count, n_rd);
        end
    endtask

    task automatic test_corrupt();
        bit to;
        int b;
        b = $urandom_range(DEPTH - 1);
        prep_mem();
        flip[wrap(b + 5)] = 32'h0000_0001;
        flip[wrap(b + 6)] = $urandom | 32'h8000_0000;
        start_run(b, 16, 0, 1, 1);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL corrupt_timeout: got timeout want done"); end
        checks++;
        if (int'(err_count) !== exp_errs(b, 16) || err_count !== 16'd2) begin
            errors++; $display("FAIL corrupt_count: got %0d want %0d", err_count, exp_errs(b, 16));
        end
        checks++;
        if (int'(first_err_addr) !== wrap(b + 5)) begin
            errors++; $display("FAIL corrupt_first: got %0h want %0h", first_err_addr, wrap(b + 5));
        end
    endtask

    task automatic test_zero_count();
        bit to;
        prep_mem();
        start_run($urandom_range(DEPTH - 1), 0, 0, 1, 1);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL zero_timeout: got timeout want done"); end
        checks++;
        if (done_cyc - start_cyc !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL zero_done: got delay=%0d pulses=%0d want 1/1", done_cyc - start_cyc, done_cnt);
        end
        checks++;
        if (traffic !== 0) begin errors++; $display("FAIL zero_traffic: got %0d want 0", traffic); end
        checks++;
        if (err_count !== 16'd0) begin errors++; $display("FAIL zero_err: got %0d want 0", err_count); end
    endtask

    task automatic test_random();
        bit to;
        int b, n;
        for (int it = 0; it < 3; it++) begin
            b = $urandom_range(DEPTH - 1);
            n = $urandom_range(60, 20);
            prep_mem();
            if (it == 2) begin
                flip[wrap(b + $urandom_range(n / 2 - 1))] = $urandom | 32'h1;
                flip[wrap(b + n / 2 + $urandom_range(n / 2 - 1))] = $urandom | 32'h1;
            end
            start_run(b, n, 50, 1, 6);
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL rand%0d_timeout: got timeout want done", it); end
            checks++;
            if (int'(err_count) !== exp_errs(b, n) || int'(first_err_addr) !== exp_first(b, n)) begin
                errors++; $display("FAIL rand%0d_err: got %0d/%0h want %0d/%0h", it, err_count,
                                   first_err_addr, exp_errs(b, n), exp_first(b, n));
            end
            checks++;
            if (mem_bad(b, n) !== 0 || n_rd !== n) begin
                errors++; $display("FAIL rand%0d_mem: got bad=%0d rd=%0d want 0/%0d", it, mem_bad(b, n), n_rd, n);
            end
            checks++;
            if (max_out > MAX_PENDING || viol_stable !== 0 || viol_both !== 0) begin
                errors++; $display("FAIL rand%0d_protocol: got pend=%0d stable=%0d both=%0d want <=%0d/0/0",
                                   it, max_out, viol_stable, viol_both, MAX_PENDING);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        prep_mem();
        start_run(100, 20, 0, 2, 2);
        repeat (3) @(negedge clk);
        #1;
        base_addr = 12'h800; word_count = 13'd5; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL ignore_timeout: got timeout want done"); end
        checks++;
        if (mem_bad(100, 20) !== 0 || mem[12'h800] !== SENTINEL) begin
            errors++; $display("FAIL ignore_mem: got bad=%0d m800=%0h want 0/%0h", mem_bad(100, 20), mem[12'h800], SENTINEL);
        end
        checks++;
        if (n_wr !== 20 || done_cnt !== 1) begin
            errors++; $display("FAIL ignore_counts: got wr=%0d done=%0d want 20/1", n_wr, done_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done_cnt !== 1) begin
            errors++; $display("FAIL ignore_rerun: got busy=%b done=%0d want 0/1", busy, done_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        bit to, found;
        int b;
        b = $urandom_range(DEPTH - 1);
        prep_mem();
        start_run(b, 32, 0, 6, 6);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (n_rd > 0 && outstanding == 3) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midrd_reach: got no 3-outstanding point want one"); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, avm_read, avm_write} !== 4'b0000 || avm_address !== '0 || avm_writedata !== '0) begin
            errors++; $display("FAIL midrd_outputs: got ctrl=%b addr=%0h wd=%0h want 0", {busy, done, avm_read, avm_write},
                               avm_address, avm_writedata);
        end
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        b = $urandom_range(DEPTH - 1);
        prep_mem();
        start_run(b, 24, 30, 1, 6);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL midrd_timeout: got timeout want done"); end
        checks++;
        if (err_count !== 16'd0 || mem_bad(b, 24) !== 0) begin
            errors++; $display("FAIL midrd_clean: got err=%0d bad=%0d want 0/0", err_count, mem_bad(b, 24));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        wait_pct = 0; lat_min = 1; lat_max = 1;
        n_wr = 0; n_rd = 0; first_wr_cyc = -1; last_wr_cyc = -1; max_out = 0;
        viol_stable = 0; viol_both = 0; viol_be = 0; viol_align = 0; traffic = 0;
        done_cnt = 0; done_cyc = -1; start_cyc = 0;
        prep_mem();
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_corrupt();
        test_zero_count();
        test_random();
        test_start_ignored();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
